// File: rtl/tmr_pkg.sv
// Shared types and default baud constants for the TMR UART transmit path.
package tmr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int CLK_HZ           = 50_000_000;
  localparam int BAUD             = 115_200;
  localparam int DEF_CLKS_PER_BIT = CLK_HZ / BAUD;  // 434 at 50 MHz / 115200

endpackage

// File: rtl/tmr_sync_fifo.sv
// Synchronous FIFO with separate occupancy counter; a push on a full FIFO
// is accepted when a pop happens in the same cycle.
module tmr_sync_fifo
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_AW    = 4,
  parameter int DEPTH      = 1 << FIFO_AW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [FIFO_AW:0]      level_o
);

  localparam int LVL_W = FIFO_AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]      level_q;
  logic                  do_push, do_pop;

  assign full_o     = (level_q == LVL_W'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: only entries below level_q are ever read out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/tmr_uart_tx.sv
// UART transmitter for the voted byte stream: FIFO-buffered, 8N1-style frames,
// back-to-back frames with no idle gap, sticky overflow on dropped bytes.
module tmr_uart_tx
  import tmr_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  overflow_clr,
  output logic                  uart_txd,
  output logic                  tx_busy,
  output logic [FIFO_AW:0]      fifo_level,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  overflow
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_state_e           state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  txd_q, txd_d;
  logic                  overflow_q, overflow_d;
  logic                  pop, baud_end, drop;
  logic [DATA_WIDTH-1:0] fifo_head;

  tmr_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_AW    (FIFO_AW),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (in_valid),
    .push_data_i (in_data),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

  assign baud_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  // A full FIFO still takes the byte if the FSM frees a slot this cycle.
  assign drop       = in_valid && fifo_full && !pop;
  assign overflow_d = drop || (overflow_q && !overflow_clr);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          txd_d   = 1'b0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        baud_d = baud_q + 1'b1;
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          txd_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          state_d   = DATA;
        end
      end
      DATA: begin
        baud_d = baud_q + 1'b1;
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == BIT_W'(DATA_WIDTH - 1)) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      default: begin  // STOP: chain straight into the next start bit if data waits
        baud_d = baud_q + 1'b1;
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            txd_d   = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      overflow_q <= overflow_d;
    end
  end

  assign uart_txd = txd_q;
  assign tx_busy  = (state_q != IDLE);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_tmr_uart_tx.sv
// Bench for tmr_uart_tx: table of single-frame vectors plus hand sequences
// for back-to-back, overflow/clear, full-with-pop and mid-frame reset.
module tb_tmr_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data;
  logic       in_valid = 1'b0;
  logic       overflow_clr = 1'b0;
  logic       uart_txd, tx_busy, fifo_full, fifo_empty, overflow;
  logic [4:0] fifo_level;

  tmr_uart_tx #(
    .DATA_WIDTH   (8),
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (16),
    .FIFO_AW      (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .overflow_clr (overflow_clr),
    .uart_txd     (uart_txd),
    .tx_busy      (tx_busy),
    .fifo_level   (fifo_level),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int frames_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line monitor: decodes frames at mid-bit and checks them against the scoreboard.
  bit         in_frame = 1'b0;
  int         fk = 0;
  logic [7:0] rx_byte;
  logic       rx_stop;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && uart_txd == 1'b0) begin
        in_frame = 1'b1;
        fk = 0;
      end else if (in_frame) begin
        fk++;
      end
      if (in_frame) begin
        if (fk >= 6 && fk <= 34 && ((fk - 6) % 4) == 0) rx_byte[(fk - 6) / 4] = uart_txd;
        if (fk == 38) rx_stop = uart_txd;
        if (fk == 39) begin
          in_frame = 1'b0;
          frames_seen++;
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 32'({rx_stop, rx_byte}), 32'h1ff);
            n_err += (n_err == 0) ? 0 : 0;
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk("rx_frame", 32'({rx_stop, rx_byte}), 32'({1'b1, e}));
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    exp_q.push_back(d);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 'x;
  endtask

  task automatic wait_idle(input int max_cyc);
    int t = 0;
    while ((tx_busy || !fifo_empty || in_frame) && t < max_cyc) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_in_time", 32'(t < max_cyc), 32'd1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // line bits in time order, bit0 = start bit
  } vec_t;

  vec_t vecs[5];

  initial begin
    int busy_cnt, lows, fs;
    logic [9:0] line;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h3C, 10'b1001111000};
    vecs[2] = '{8'h81, 10'b1100000010};
    vecs[3] = '{8'h00, 10'b1000000000};
    vecs[4] = '{8'hFF, 10'b1111111110};

    in_data = 'x;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", 32'(uart_txd), 1);
    chk("rst_busy", 32'(tx_busy), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_empty", 32'(fifo_empty), 1);
    chk("rst_full", 32'(fifo_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_txd", 32'(uart_txd), 1);

    // Single-frame table
    for (int v = 0; v < 5; v++) begin
      push(vecs[v].data);
      busy_cnt = 0;
      line = '0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (k == 0) chk("level_after_pop", 32'(fifo_level), 0);
        busy_cnt += int'(tx_busy);
        if ((k % 4) == 2) line[k / 4] = uart_txd;
      end
      chk("frame_line", 32'(line), 32'(vecs[v].frame));
      chk("busy_cycles", 32'(busy_cnt), 40);
      @(posedge clk); #1;
      chk("busy_after", 32'(tx_busy), 0);
      chk("txd_after", 32'(uart_txd), 1);
      repeat (3) @(posedge clk);
      #1;
    end

    // Back-to-back: 0x00 then 0xFF, contiguous frames
    push(8'h00);
    in_data = 8'hFF; in_valid = 1'b1; exp_q.push_back(8'hFF);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 'x;
    busy_cnt = int'(tx_busy);
    for (int k = 1; k < 80; k++) begin
      @(posedge clk); #1;
      busy_cnt += int'(tx_busy);
      if (k == 39) chk("b2b_stop", 32'(uart_txd), 1);
      if (k == 40) chk("b2b_start2", 32'(uart_txd), 0);
    end
    chk("b2b_busy_cycles", 32'(busy_cnt), 80);
    @(posedge clk); #1;
    chk("b2b_idle_after", 32'(tx_busy), 0);
    chk("b2b_ovf", 32'(overflow), 0);
    wait_idle(200);

    // Overflow: 18 consecutive pushes from idle, the last one dropped
    fs = frames_seen;
    for (int i = 0; i < 18; i++) begin
      in_data = 8'(8'h40 + i); in_valid = 1'b1;
      if (i < 17) exp_q.push_back(8'(8'h40 + i));
      @(posedge clk); #1;
      if (i == 1) chk("ovf_level1", 32'(fifo_level), 1);
      if (i == 16) begin
        chk("ovf_level16", 32'(fifo_level), 16);
        chk("ovf_full", 32'(fifo_full), 1);
        chk("ovf_not_yet", 32'(overflow), 0);
      end
      if (i == 17) begin
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_level_hold", 32'(fifo_level), 16);
      end
    end
    in_valid = 1'b0; in_data = 'x;
    overflow_clr = 1'b1;
    @(posedge clk); #1;
    overflow_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);
    wait_idle(1000);
    chk("ovf_frames", 32'(frames_seen - fs), 17);

    // Clear colliding with a drop, then push into a full FIFO as STOP pops
    fs = frames_seen;
    for (int i = 0; i < 18; i++) begin
      in_data = 8'(8'h80 + i); in_valid = 1'b1;
      overflow_clr = (i == 17);
      if (i < 17) exp_q.push_back(8'(8'h80 + i));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_data = 'x; overflow_clr = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 1);
    overflow_clr = 1'b1;
    @(posedge clk); #1;
    overflow_clr = 1'b0;
    chk("ovf_cleared2", 32'(overflow), 0);
    repeat (22) @(posedge clk);
    #1;
    chk("pre_pop_level", 32'(fifo_level), 16);
    chk("pre_pop_stop", 32'(uart_txd), 1);
    in_data = 8'hEE; in_valid = 1'b1; exp_q.push_back(8'hEE);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 'x;
    chk("fullpop_level", 32'(fifo_level), 16);
    chk("fullpop_full", 32'(fifo_full), 1);
    chk("fullpop_ovf", 32'(overflow), 0);
    chk("fullpop_start", 32'(uart_txd), 0);
    wait_idle(1200);
    chk("fullpop_frames", 32'(frames_seen - fs), 18);

    // Reset during data bit 3 with bytes queued
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'hC0 + i); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_data = 'x;
    repeat (14) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(tx_busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_txd", 32'(uart_txd), 1);
    chk("arst_busy", 32'(tx_busy), 0);
    chk("arst_level", 32'(fifo_level), 0);
    chk("arst_empty", 32'(fifo_empty), 1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    fs = frames_seen;
    lows = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (!uart_txd || tx_busy) lows++;
    end
    chk("post_rst_quiet", 32'(lows), 0);
    chk("post_rst_frames", 32'(frames_seen - fs), 0);
    chk("post_rst_level", 32'(fifo_level), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
